// File: rtl/mul_ctrl.sv
// mul_ctrl: RV32M multiply sequencer with one-entry operand/product cache in front of a signed Booth multiplier
module mul_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        busy,
  output logic [31:0] mul_A,
  output logic [31:0] mul_B,
  output logic        mul_rst,
  input  logic [63:0] mul_P,
  input  logic        mul_done
);
  typedef enum logic [2:0] {IDLE, START, WAIT, FIX, RESP} state_t;
  state_t state, state_n;
  logic [1:0] op_q;
  logic [31:0] a_q, b_q, cache_a, cache_b, hi_s, fix_res;
  logic [63:0] cache_p;
  logic cache_v, accept, hit;
  assign accept = state == IDLE && req_valid && !flush;
  assign hit = cache_v && req_a == cache_a && req_b == cache_b;
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  assign resp_valid = state == RESP;
  assign mul_rst = state == START && !flush;
  assign hi_s = cache_p[63:32];
  // the multiplier is signed-only; add back the terms dropped by treating unsigned operands as negative
  assign fix_res = op_q == 2'd0 ? cache_p[31:0] :
                   op_q == 2'd1 ? hi_s :
                   op_q == 2'd2 ? hi_s + (b_q[31] ? a_q : 32'd0) :
                   hi_s + (a_q[31] ? b_q : 32'd0) + (b_q[31] ? a_q : 32'd0);
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? (hit ? FIX : START) : IDLE;
      START:   state_n = WAIT;
      WAIT:    state_n = mul_done ? FIX : WAIT;
      FIX:     state_n = RESP;
      RESP:    state_n = resp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      cache_v <= 1'b0;
      resp_data <= 32'd0;
      mul_A <= 32'd0;
      mul_B <= 32'd0;
    end else begin
      if (accept) begin
        op_q <= req_op;
        a_q <= req_a;
        b_q <= req_b;
        if (!hit) begin
          mul_A <= req_a;
          mul_B <= req_b;
          cache_v <= 1'b0;
        end
      end
      if (state == WAIT && mul_done && !flush) begin
        cache_p <= mul_P;
        cache_a <= a_q;
        cache_b <= b_q;
        cache_v <= 1'b1;
      end
      if (state == FIX && !flush) resp_data <= fix_res;
    end
endmodule

// File: tb/tb_mul_ctrl.sv
// tb_mul_ctrl: scoreboard bench for mul_ctrl with a behavioural multiplier and random requests
module tb_mul_ctrl;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, req_valid = 1'b0, resp_ready = 1'b1;
  logic [1:0] req_op = 2'd0;
  logic [31:0] req_a = 32'd0, req_b = 32'd0;
  logic req_ready, resp_valid, busy, mul_rst;
  logic [31:0] resp_data, mul_A, mul_B;
  logic [63:0] mul_P = 64'd0;
  logic done_r = 1'b0, mul_done;
  logic [31:0] pa = 32'd0, pb = 32'd0;
  int cnt = 0, force_lat = 0;
  int tests = 0, fails = 0, n_resp = 0, n_rst = 0;
  logic [31:0] exp_q[$];
  logic [31:0] edge_v[5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

  mul_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .busy(busy), .mul_A(mul_A),
    .mul_B(mul_B), .mul_rst(mul_rst), .mul_P(mul_P), .mul_done(mul_done)
  );

  always #5 clk = ~clk;

  // multiplier stand-in: signed product after a random latency, done held until the next start
  assign mul_done = done_r && !mul_rst;
  always @(posedge clk)
    if (mul_rst) begin
      cnt <= force_lat != 0 ? force_lat : int'($urandom_range(1, 40));
      done_r <= 1'b0;
      pa <= mul_A;
      pb <= mul_B;
    end else if (cnt > 1) cnt <= cnt - 1;
    else if (cnt == 1) begin
      cnt <= 0;
      done_r <= 1'b1;
      mul_P <= {{32{pa[31]}}, pa} * {{32{pb[31]}}, pb};
    end

  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] xa = {{32{a[31] & (op != 2'd3)}}, a};
    logic [63:0] xb = {{32{b[31] & !op[1]}}, b};
    logic [63:0] p = xa * xb;
    return op == 2'd0 ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick();
    return $urandom_range(0, 1) != 0 ? 32'($urandom) : edge_v[$urandom_range(0, 4)];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (mul_rst) n_rst++;
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_resp: got %h with empty scoreboard", resp_data);
        end else chk("resp_data", resp_data, exp_q.pop_front());
        n_resp++;
      end
    end
  endtask

  // returns one cycle after the acceptance edge (the START or FIX cycle)
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
    int n = 0;
    while (!req_ready && n < 200) begin step(); n++; end
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
    end
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    if (push) exp_q.push_back(ref_res(op, a, b));
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int base, input bit rnd);
    int n = 0;
    while (n_resp == base && n < 300) begin
      resp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      n++;
    end
    resp_ready = 1'b1;
    if (n_resp == base) begin
      tests++;
      fails++;
      $display("FAIL resp_timeout: got no response expected one");
    end
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, p0, n;
    bit saw, c_v;
    logic [31:0] a, b, d, c_a, c_b;
    logic [1:0] op;
    fork monitor(); join_none
    repeat (3) step();
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mul_rst", 32'(mul_rst), 0);
    chk("rst_mul_A", mul_A, 0);
    chk("rst_mul_B", mul_B, 0);
    chk("rst_resp_data", resp_data, 0);
    rst = 1'b0;
    step();
    // MUL miss with timing relative to first mul_done
    base = n_resp; p0 = n_rst;
    send(2'd0, 32'd3, 32'hFFFFFFFB, 1);
    chk("t1_mul_rst", 32'(mul_rst), 1);
    step();
    n = 0;
    while (!mul_done && n < 100) begin step(); n++; end
    chk("t1_done_seen", 32'(mul_done), 1);
    step();
    chk("t1_fix_no_valid", 32'(resp_valid), 0);
    step();
    chk("t1_valid_k2", 32'(resp_valid), 1);
    wait_resp(base, 0);
    chk("t1_pulses", 32'(n_rst - p0), 1);
    // MULHU miss then MULH hit on the same operands
    base = n_resp;
    send(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    wait_resp(base, 0);
    base = n_resp; p0 = n_rst;
    send(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    chk("t2_hit_no_rst", 32'(mul_rst), 0);
    step();
    chk("t2_valid_t0p2", 32'(resp_valid), 1);
    wait_resp(base, 0);
    chk("t2_hit_pulses", 32'(n_rst - p0), 0);
    // MULHSU then MULHU corrections
    base = n_resp;
    send(2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    wait_resp(base, 0);
    base = n_resp;
    send(2'd3, 32'h80000000, 32'd2, 1);
    wait_resp(base, 0);
    // backpressure
    resp_ready = 1'b0;
    send(2'd2, 32'($urandom), 32'($urandom), 1);
    n = 0;
    while (!resp_valid && n < 100) begin step(); n++; end
    chk("t4_valid", 32'(resp_valid), 1);
    d = resp_data;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t4_hold_valid", 32'(resp_valid), 1);
      chk("t4_hold_data", resp_data, d);
      chk("t4_hold_req_ready", 32'(req_ready), 0);
    end
    resp_ready = 1'b1;
    step();
    chk("t4_idle_req_ready", 32'(req_ready), 1);
    chk("t4_idle_valid", 32'(resp_valid), 0);
    // flush in WAIT, then the same operands must miss
    a = 32'($urandom); b = 32'($urandom) | 32'h1;
    force_lat = 30;
    send(2'd0, a, b, 0);
    repeat (5) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t5_req_ready", 32'(req_ready), 1);
    chk("t5_busy", 32'(busy), 0);
    saw = 1'b0;
    repeat (40) begin step(); if (resp_valid) saw = 1'b1; end
    chk("t5_no_resp", 32'(saw), 0);
    force_lat = 0;
    base = n_resp;
    send(2'd0, a, b, 1);
    chk("t5_reissue_miss", 32'(mul_rst), 1);
    wait_resp(base, 0);
    // rst in WAIT
    a = 32'($urandom); b = 32'($urandom) | 32'h2;
    force_lat = 30;
    send(2'd1, a, b, 0);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6w_resp_valid", 32'(resp_valid), 0);
    chk("t6w_req_ready", 32'(req_ready), 1);
    chk("t6w_busy", 32'(busy), 0);
    force_lat = 0;
    base = n_resp;
    send(2'd1, a, b, 1);
    chk("t6w_miss", 32'(mul_rst), 1);
    wait_resp(base, 0);
    // rst in RESP after a cache hit; the cache must not survive
    resp_ready = 1'b0;
    send(2'd3, a, b, 0);
    chk("t6r_hit", 32'(mul_rst), 0);
    n = 0;
    while (!resp_valid && n < 100) begin step(); n++; end
    rst = 1'b1;
    step();
    rst = 1'b0;
    resp_ready = 1'b1;
    chk("t6r_resp_valid", 32'(resp_valid), 0);
    chk("t6r_req_ready", 32'(req_ready), 1);
    chk("t6r_busy", 32'(busy), 0);
    chk("t6r_resp_data", resp_data, 0);
    base = n_resp;
    send(2'd3, a, b, 1);
    chk("t6r_miss", 32'(mul_rst), 1);
    wait_resp(base, 0);
    // random traffic with operand reuse and random backpressure
    c_v = 1'b1; c_a = a; c_b = b;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) != 0) begin a = pick(); b = pick(); end
      op = 2'($urandom_range(0, 3));
      base = n_resp;
      send(op, a, b, 1);
      chk("rnd_miss_rst", 32'(mul_rst), 32'(!(c_v && a == c_a && b == c_b)));
      wait_resp(base, 1);
      c_v = 1'b1; c_a = a; c_b = b;
    end
    repeat (3) step();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
